cmd_tx_buffer: RTL and testbench
================================

Name: cmd_tx_buffer

Overview:
- Parametrised multi-slot command transmit buffer; successor to the fixed 2048x9, two-template command memory.
- Stores SLOTS command frames of up to SLOT_DEPTH words, each DATA_W data bits plus 1 control-marker bit.
- Each slot has a host-programmed length register.
- On a start request, streams the selected slot to the TX framer over a valid/ready interface with last-word marking, sustaining one word per clock.

Parameters:
- DATA_W, 8, payload bits per word; stored word width is DATA_W+1 (MSB = control marker).
- SLOTS, 2, number of frame slots; must be a power of 2, ≥2.
- SLOT_DEPTH, 1024, words per slot; must be a power of 2.
- SLOT_W, $clog2(SLOTS), slot index width (derived).
- ADDR_W, $clog2(SLOT_DEPTH), word address width (derived).
- LEN_W, ADDR_W+1, length field width (derived).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  host word write strobe.
- wr_slot  in  SLOT_W  target slot of the write.
- wr_addr  in  ADDR_W  word address within the slot.
- wr_data  in  DATA_W+1  word; bit DATA_W = control marker.
- wr_err  out  1  one-cycle pulse: write dropped.
- len_we  in  1  length register write strobe.
- len_slot  in  SLOT_W  slot whose length is written.
- len_val  in  LEN_W  frame length in words.
- start  in  1  transmit request, single-cycle.
- start_slot  in  SLOT_W  slot to transmit.
- start_err  out  1  one-cycle pulse: start rejected.
- busy  out  1  a frame is in flight.
- done  out  1  one-cycle pulse after the last word handshakes.
- tx_data  out  DATA_W  payload.
- tx_ctrl  out  1  control marker of the current word.
- tx_last  out  1  final word of the frame.
- tx_valid  out  1  word available.
- tx_ready  in  1  downstream accepts.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous, active-low.
- Reset values:
  - All outputs 0.
  - All length registers 0.
  - FSM in IDLE; skid buffer emptied.
  - Memory contents are not cleared.
- Reset mid-frame: the frame is aborted; tx_valid is 0 in the cycle after the reset edge; no done pulse.
- Memory: SLOTS*SLOT_DEPTH x (DATA_W+1) simple dual port, inferred block RAM.
  - Physical address = {slot, addr}.
  - Registered read, 1-cycle latency, read-before-write.
- Writes:
  - Accepted on any cycle, except when wr_slot equals the active slot while busy=1. In that case the word is dropped and wr_err pulses on the next cycle.
  - Writes to other slots during streaming are always accepted.
- Length writes:
  - Same protection as writes; a rejected length write also pulses wr_err.
  - len_val > SLOT_DEPTH is stored saturated to SLOT_DEPTH.
- FSM states: IDLE, PRIME, STREAM, FLUSH.
  - IDLE: start with length ≠ 0 → latch slot and length, issue read of word 0, go to PRIME; busy=1 from the next cycle.
  - IDLE, start with length = 0: start_err pulses next cycle, FSM stays IDLE.
  - start while busy: ignored; start_err pulses next cycle.
  - PRIME: read data lands in the output register; tx_valid asserts. First tx_valid occurs on the 2nd rising edge after the start-accepting edge. Go to STREAM.
  - STREAM: reads are issued ahead, with a 2-entry skid buffer, so that with tx_ready held high one word transfers per clock with no bubbles. Backpressure never loses or duplicates a word. tx_data, tx_ctrl and tx_last are held stable while tx_valid=1 and tx_ready=0.
  - tx_last = 1 exactly on word index length-1. tx_ctrl passes bit DATA_W through; it does not terminate the frame.
  - After the last read is issued → FLUSH.
  - FLUSH: drain the skid buffer. On the handshake of the tx_last word, done pulses in the following cycle, busy drops in that same cycle, and the FSM returns to IDLE.
- A start in the same cycle as done's handshake edge is rejected (busy still 1). Earliest accepted start is the cycle done is high.
- Length 1 frame: a single word with tx_last=1.
- Length SLOT_DEPTH frame: the word counter must not wrap into the next slot.
- Simultaneous wr_en and len_we are independent; both may complete in one cycle.

Test Plan:
- Reset, write slot 1 words 0..3 = 0x1AA, 0x055, 0x0FF, 0x100; len[1]=4; start slot 1, tx_ready=1 → tx_valid on 2nd edge after start; 4 consecutive words AA,55,FF,00; tx_ctrl 1,0,0,1; tx_last only on 4th; done pulses once; busy falls with done.
- Same frame with tx_ready toggled 1,0,0,1,0,1... → identical word sequence, no duplicates or losses; outputs stable during stalls.
- start with len=0 → start_err pulse, busy stays 0, no tx_valid. Start slot 0 while slot 1 streaming → start_err, stream unaffected.
- While slot 1 streams: write slot 1 → wr_err pulse and memory unchanged (re-stream and compare). Write slot 0 → accepted.
- len_val = SLOT_DEPTH+5 → saturates; exactly SLOT_DEPTH words streamed, last = word SLOT_DEPTH-1, no word from the next slot.
- Assert reset_n=0 mid-stream (word 2 of 4) → tx_valid=0 next cycle, no done; after release, len registers read back as 0 (start gives start_err).

Source files
------------

// File: rtl/cmd_tx_buffer.sv
// Multi-slot command transmit buffer: host-written frame slots with per-slot
// lengths, streamed to a TX framer over valid/ready with last-word marking.
module cmd_tx_buffer #(
  parameter  int DATA_W     = 8,
  parameter  int SLOTS      = 2,
  parameter  int SLOT_DEPTH = 1024,
  localparam int SLOT_W     = $clog2(SLOTS),
  localparam int ADDR_W     = $clog2(SLOT_DEPTH),
  localparam int LEN_W      = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W:0]   wr_data,
  output logic              wr_err,
  input  logic              len_we,
  input  logic [SLOT_W-1:0] len_slot,
  input  logic [LEN_W-1:0]  len_val,
  input  logic              start,
  input  logic [SLOT_W-1:0] start_slot,
  output logic              start_err,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_ctrl,
  output logic              tx_last,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, FLUSH} state_e;

  typedef struct packed {
    logic              last;
    logic              ctrl;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   act_slot_q, act_slot_d;
  logic [LEN_W-1:0]    act_len_q, act_len_d;
  logic [LEN_W-1:0]    rd_idx_q, rd_idx_d;
  logic [LEN_W-1:0]    len_q [SLOTS];
  logic [LEN_W-1:0]    len_sat;

  logic [DATA_W:0]     mem [SLOTS*SLOT_DEPTH];
  logic [DATA_W:0]     mem_rd_q;
  logic                rd_en, rd_last, rd_vld_q, rd_last_q;
  logic [SLOT_W+ADDR_W-1:0] rd_addr;

  ent_t                in_ent;
  ent_t                out_q, out_d;
  logic                out_vld_q, out_vld_d;
  ent_t                skid_q [2];
  ent_t                skid_d [2];
  logic [1:0]          cnt_q, cnt_d;

  logic                done_q, done_d, start_err_q, wr_err_q;
  logic                wr_block, len_block, wr_ok, start_ok;

  assign busy      = (state_q != IDLE);
  assign wr_block  = busy && (wr_slot == act_slot_q);
  assign len_block = busy && (len_slot == act_slot_q);
  assign wr_ok     = wr_en && !wr_block;
  assign start_ok  = start && !busy && (len_q[start_slot] != '0);
  assign len_sat   = (len_val > LEN_W'(SLOT_DEPTH)) ? LEN_W'(SLOT_DEPTH) : len_val;
  assign rd_addr   = {act_slot_q, rd_idx_q[ADDR_W-1:0]};
  assign rd_last   = (rd_idx_q == act_len_q - LEN_W'(1));

  // NOTE: no reset on the array or its read register, so both map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[{wr_slot, wr_addr}] <= wr_data;
    if (rd_en) mem_rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++) len_q[i] <= '0;
    end else if (len_we && !len_block) begin
      len_q[len_slot] <= len_sat;
    end
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    act_slot_d = act_slot_q;
    act_len_d  = act_len_q;
    rd_idx_d   = rd_idx_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rd_en      = 1'b0;
    in_ent.last = rd_last_q;
    in_ent.ctrl = mem_rd_q[DATA_W];
    in_ent.data = mem_rd_q[DATA_W-1:0];

    // Output register refills from the skid head first so word order is kept.
    if (!out_vld_q || tx_ready) begin
      out_vld_d = 1'b0;
      if (cnt_q != 2'd0) begin
        out_d     = skid_q[0];
        out_vld_d = 1'b1;
        skid_d[0] = skid_q[1];
        cnt_d     = cnt_q - 2'd1;
        if (rd_vld_q) begin
          if (cnt_q == 2'd1) skid_d[0] = in_ent;
          else               skid_d[1] = in_ent;
          cnt_d = cnt_q;
        end
      end else if (rd_vld_q) begin
        out_d     = in_ent;
        out_vld_d = 1'b1;
      end
    end else if (rd_vld_q) begin
      if (cnt_q == 2'd0) skid_d[0] = in_ent;
      else               skid_d[1] = in_ent;
      cnt_d = cnt_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          act_slot_d = start_slot;
          act_len_d  = len_q[start_slot];
          rd_idx_d   = '0;
          state_d    = PRIME;
        end
      end
      PRIME, STREAM: begin
        // A read is only issued when the skid buffer is guaranteed a free entry.
        if (cnt_d != 2'd2) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + LEN_W'(1);
          state_d  = rd_last ? FLUSH : STREAM;
        end
      end
      FLUSH: begin
        if (out_vld_q && tx_ready && out_q.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      act_slot_q  <= '0;
      act_len_q   <= '0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '{default: '0};
      cnt_q       <= 2'd0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_slot_q  <= act_slot_d;
      act_len_q   <= act_len_d;
      rd_idx_q    <= rd_idx_d;
      rd_vld_q    <= rd_en;
      if (rd_en) rd_last_q <= rd_last;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      start_err_q <= start && !start_ok;
      wr_err_q    <= (wr_en && wr_block) || (len_we && len_block);
    end
  end

  assign done      = done_q;
  assign start_err = start_err_q;
  assign wr_err    = wr_err_q;
  assign tx_valid  = out_vld_q;
  assign tx_data   = out_q.data;
  assign tx_ctrl   = out_q.ctrl;
  assign tx_last   = out_q.last;

endmodule

// File: tb/tb_cmd_tx_buffer.sv
// Self-checking bench for cmd_tx_buffer: table-driven frame contents, a word
// scoreboard fed at start time, and hand-written multi-cycle corner cases.
module tb_cmd_tx_buffer;

  localparam int DATA_W     = 8;
  localparam int SLOTS      = 2;
  localparam int SLOT_DEPTH = 1024;
  localparam int SLOT_W     = $clog2(SLOTS);
  localparam int ADDR_W     = $clog2(SLOT_DEPTH);
  localparam int LEN_W      = ADDR_W + 1;

  logic              clk, reset_n;
  logic              wr_en, len_we, start, tx_ready;
  logic [SLOT_W-1:0] wr_slot, len_slot, start_slot;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W:0]   wr_data;
  logic [LEN_W-1:0]  len_val;
  logic              wr_err, start_err, busy, done, tx_ctrl, tx_last, tx_valid;
  logic [DATA_W-1:0] tx_data;

  cmd_tx_buffer #(.DATA_W(DATA_W), .SLOTS(SLOTS), .SLOT_DEPTH(SLOT_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_slot(wr_slot), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .len_we(len_we), .len_slot(len_slot), .len_val(len_val),
    .start(start), .start_slot(start_slot), .start_err(start_err),
    .busy(busy), .done(done),
    .tx_data(tx_data), .tx_ctrl(tx_ctrl), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W:0]   wr_word;
    logic [7:0]        exp_data;
    logic              exp_ctrl;
    logic              exp_last;
  } vec_t;

  vec_t          vecs [4];
  logic [9:0]    exp_q [$];
  logic [DATA_W:0] mdl [SLOT_DEPTH];
  int            n_cmp = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  int            hs_cnt = 0;
  int            ready_mode = 0;   // 0: always ready, 1: toggle pattern, 2: never ready
  logic          held_vld = 1'b0;
  logic [9:0]    held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  initial begin
    int pidx;
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pidx = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin tx_ready = pat[pidx]; pidx = (pidx + 1) % 6; end
        2: tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard pop on handshake, stall stability, done/busy relation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (held_vld)
        check("stall_hold", {tx_valid, tx_ctrl, tx_last, tx_data}, {1'b1, held});
      if (done) begin
        done_cnt++;
        check("busy_with_done", busy, 0);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word actual=%0h expected=none at %0t",
                   {tx_ctrl, tx_last, tx_data}, $time);
        end else begin
          check("tx_word", {tx_ctrl, tx_last, tx_data}, exp_q.pop_front());
          hs_cnt++;
        end
      end
      held_vld = tx_valid && !tx_ready;
      held     = {tx_ctrl, tx_last, tx_data};
    end else begin
      held_vld = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int s, input int a, input logic [DATA_W:0] d);
    wr_en = 1'b1; wr_slot = SLOT_W'(s); wr_addr = ADDR_W'(a); wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wr_len(input int s, input int v);
    len_we = 1'b1; len_slot = SLOT_W'(s); len_val = LEN_W'(v);
    cyc();
    len_we = 1'b0;
  endtask

  task automatic start_frame(input int s);
    start = 1'b1; start_slot = SLOT_W'(s);
    cyc();
    start = 1'b0;
  endtask

  task automatic push_table();
    foreach (vecs[i]) exp_q.push_back({vecs[i].exp_ctrl, vecs[i].exp_last, vecs[i].exp_data});
  endtask

  task automatic wait_frame(input int budget);
    for (int k = 0; k < budget; k++) begin
      cyc();
      if (exp_q.size() == 0 && !busy && !tx_valid) break;
    end
    check("frame_drain", exp_q.size(), 0);
    check("frame_idle", busy, 0);
    cyc();
    cyc();
  endtask

  initial begin
    vecs[0] = '{addr: 0, wr_word: 9'h1AA, exp_data: 8'hAA, exp_ctrl: 1'b1, exp_last: 1'b0};
    vecs[1] = '{addr: 1, wr_word: 9'h055, exp_data: 8'h55, exp_ctrl: 1'b0, exp_last: 1'b0};
    vecs[2] = '{addr: 2, wr_word: 9'h0FF, exp_data: 8'hFF, exp_ctrl: 1'b0, exp_last: 1'b0};
    vecs[3] = '{addr: 3, wr_word: 9'h100, exp_data: 8'h00, exp_ctrl: 1'b1, exp_last: 1'b1};

    reset_n = 1'b0; wr_en = 1'b0; len_we = 1'b0; start = 1'b0;
    wr_slot = '0; wr_addr = '0; wr_data = '0; len_slot = '0; len_val = '0; start_slot = '0;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_outputs", {tx_valid, busy, done, wr_err, start_err, tx_ctrl, tx_last, tx_data}, 0);
    reset_n = 1'b1;
    cyc();

    // Slot 1 from the table; the final word and its length land in the same cycle.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_slot = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].wr_word;
      if (i == 3) begin len_we = 1'b1; len_slot = 1'b1; len_val = LEN_W'(4); end
      cyc();
      wr_en = 1'b0; len_we = 1'b0;
    end
    @(negedge clk);
    check("wr_len_same_cycle_err", wr_err, 0);
    for (int i = 0; i < 5; i++) wr_word(0, i, 9'(9'h030 + i));

    // Basic frame with first-word latency.
    push_table();
    start_frame(1);
    @(negedge clk);
    check("lat_edge0", {busy, tx_valid, start_err}, 3'b100);
    cyc();
    @(negedge clk);
    check("lat_edge1", tx_valid, 0);
    cyc();
    @(negedge clk);
    check("lat_edge2", tx_valid, 1);
    wait_frame(50);
    check("done_count_1", done_cnt, 1);

    // Stalled frame with protection checks while slot 1 is active.
    ready_mode = 2;
    push_table();
    start_frame(1);
    start_frame(0);
    @(negedge clk);
    check("start_while_busy_err", start_err, 1);
    check("busy_during_frame", busy, 1);
    wr_word(1, 0, 9'h000);
    @(negedge clk);
    check("wr_active_slot_err", wr_err, 1);
    wr_len(1, 2);
    @(negedge clk);
    check("len_active_slot_err", wr_err, 1);
    wr_word(0, 5, 9'h123);
    @(negedge clk);
    check("wr_other_slot_ok", wr_err, 0);
    ready_mode = 1;
    wait_frame(100);
    check("done_count_2", done_cnt, 2);
    ready_mode = 0;

    // Slot 1 memory and length must be untouched by the rejected writes.
    push_table();
    start_frame(1);
    wait_frame(50);
    check("done_count_3", done_cnt, 3);

    // Slot 0 includes the word written while slot 1 was streaming.
    wr_len(0, 6);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 1'b0, 8'(8'h30 + i)});
    exp_q.push_back({1'b1, 1'b1, 8'h23});
    start_frame(0);
    wait_frame(50);
    check("done_count_4", done_cnt, 4);

    // Zero length is rejected and nothing streams.
    wr_len(0, 0);
    start_frame(0);
    @(negedge clk);
    check("start_len0_err", start_err, 1);
    check("start_len0_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("len0_no_valid", tx_valid, 0);
    end

    // Saturated length streams a full slot and never reaches the next slot.
    for (int i = 0; i < SLOT_DEPTH; i++) begin
      mdl[i] = 9'((i * 37 + 11) % 512);
      wr_word(0, i, mdl[i]);
    end
    wr_len(0, SLOT_DEPTH + 5);
    for (int i = 0; i < SLOT_DEPTH; i++)
      exp_q.push_back({mdl[i][DATA_W], (i == SLOT_DEPTH - 1), mdl[i][DATA_W-1:0]});
    start_frame(0);
    wait_frame(3 * SLOT_DEPTH);
    check("done_count_5", done_cnt, 5);

    // Single-word frame.
    wr_len(1, 1);
    exp_q.push_back({1'b1, 1'b1, 8'hAA});
    start_frame(1);
    wait_frame(50);
    check("done_count_6", done_cnt, 6);

    // Reset mid-frame while word 2 of 4 is on the output.
    wr_len(1, 4);
    push_table();
    begin
      int base;
      base = hs_cnt;
      start_frame(1);
      for (int k = 0; k < 50 && hs_cnt < base + 2; k++) cyc();
      check("reset_point", hs_cnt - base, 2);
    end
    reset_n = 1'b0;
    cyc();
    @(negedge clk);
    check("reset_valid_low", tx_valid, 0);
    check("reset_busy_low", busy, 0);
    check("queue_at_reset", exp_q.size(), 2);
    exp_q.delete();
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    check("no_done_after_reset", done_cnt, 6);
    start_frame(1);
    @(negedge clk);
    check("len_cleared_slot1", {start_err, busy}, 2'b10);
    start_frame(0);
    @(negedge clk);
    check("len_cleared_slot0", {start_err, busy}, 2'b10);
    cyc();
    @(negedge clk);
    check("post_reset_idle", tx_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
